// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 mouse initialisation sequencer:
//   - PS/2 command and reply byte values used during mouse bring-up
//   - frame length (start + 8 data + parity + stop)
//   - sequencer FSM state encoding
//   - odd-parity helper
// ---------------------------------------------------------------------------
package ps2_pkg;

  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_ACK        = 8'hFA;
  localparam logic [7:0] PS2_BAT_OK     = 8'hAA;
  localparam logic [7:0] PS2_MOUSE_ID   = 8'h00;
  localparam logic [7:0] PS2_RESEND     = 8'hFE;

  localparam int unsigned PS2_FRAME_LEN = 11;

  // Sequence ROM: index of the last entry and of the self-test reply,
  // which gets the long BAT timeout instead of the normal one.
  localparam logic [2:0] SEQ_LAST     = 3'd5;
  localparam logic [2:0] SEQ_BAT_STEP = 3'd2;

  typedef enum logic [2:0] {
    ST_INHIBIT,
    ST_RTS,
    ST_TX_BIT,
    ST_TX_ACK,
    ST_RX_BIT,
    ST_CHECK,
    ST_DONE,
    ST_FAIL
  } state_t;

  // Parity bit that makes the 9-bit {parity, data} group contain an odd
  // number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ---------------------------------------------------------------------------
// ps2_line_sync
// Brings the asynchronous PS/2 pins into the i_clk domain.
//   i_clk       system clock
//   i_reset     synchronous active-high reset (flops return to idle-high)
//   i_ps2_clk   raw PS/2 clock pin
//   i_ps2_data  raw PS/2 data pin
//   o_clk_fall  one-cycle pulse on a synchronised PS2Clk falling edge
//   o_data      synchronised PS2Data level, aligned with o_clk_fall
// ---------------------------------------------------------------------------
module ps2_line_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_clk_fall,
  output logic o_data
);

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;

  // Both chains use the same depth so the data level seen with a fall
  // pulse is the level that was on the pin when the device clocked it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      // Idle PS/2 lines float high; resetting to 1 avoids a false fall.
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value,
      // which is what turns this sequence of statements into a shift chain.
      clk_meta_q  <= i_ps2_clk;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= i_ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  assign o_clk_fall = clk_prev_q & ~clk_sync_q;
  assign o_data     = data_sync_q;

endmodule

// File: rtl/ps2_mouse_init.sv
// ---------------------------------------------------------------------------
// ps2_mouse_init
// Power-up sequencer for a PS/2 mouse: sends Reset (FF), expects FA AA 00,
// sends Enable Data Reporting (F4), expects FA, then opens the packet stream.
// Any bad frame, wrong reply or timeout restarts the whole sequence; after
// MAX_RETRIES restarts the block parks in a sticky error state.
//   i_clk               system clock
//   i_reset             synchronous active-high reset
//   i_PS2Clk/i_PS2Data  raw PS/2 pins (asynchronous)
//   o_PS2Clk_drive_low  1 = pull PS2Clk low, 0 = release
//   o_PS2Data_drive_low 1 = pull PS2Data low, 0 = release
//   o_stream_en         initialisation complete (held until reset)
//   o_busy              sequence in progress
//   o_error             sticky: retries exhausted
//   o_retry_cnt         restarts performed so far (saturating)
// All outputs are registered so they are all 0 while i_reset is held.
// ---------------------------------------------------------------------------
module ps2_mouse_init
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned BAT_CYCLES     = 100_000_000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_PS2Clk,
  input  logic       i_PS2Data,
  output logic       o_PS2Clk_drive_low,
  output logic       o_PS2Data_drive_low,
  output logic       o_stream_en,
  output logic       o_busy,
  output logic       o_error,
  output logic [1:0] o_retry_cnt
);

  // One counter serves both the inhibit interval and the timeouts.
  localparam int unsigned MAX_AB  = (BAT_CYCLES > TIMEOUT_CYCLES) ? BAT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_AB > INHIBIT_CYCLES + 2) ? MAX_AB : INHIBIT_CYCLES + 2;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  // Sequence ROM: which steps the host transmits and the byte of each step.
  function automatic logic seq_is_tx(input logic [2:0] idx);
    return (idx == 3'd0) || (idx == 3'd4);
  endfunction

  function automatic logic [7:0] seq_value(input logic [2:0] idx);
    logic [7:0] v;
    case (idx)
      3'd0:    v = PS2_CMD_RESET;
      3'd1:    v = PS2_ACK;
      3'd2:    v = PS2_BAT_OK;
      3'd3:    v = PS2_MOUSE_ID;
      3'd4:    v = PS2_CMD_ENABLE;
      default: v = PS2_ACK;
    endcase
    return v;
  endfunction

  logic clk_fall, data_s;

  ps2_line_sync u_sync (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_ps2_clk  (i_PS2Clk),
    .i_ps2_data (i_PS2Data),
    .o_clk_fall (clk_fall),
    .o_data     (data_s)
  );

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;     // falls seen in the current frame
  logic [8:0] shift_q, shift_d;         // {parity, data}, LSB on the wire first
  logic [2:0] step_q, step_d;
  logic [1:0] retry_q, retry_d;
  logic       clk_low_q, clk_low_d;
  logic       data_low_q, data_low_d;
  logic       stream_q, stream_d;
  logic       busy_q, busy_d;
  logic       error_q, error_d;

  logic       do_retry, timed_out;
  logic [2:0] next_step;
  logic [7:0] cur_value;
  cnt_t       limit;

  always_comb begin
    // NOTE: every next-state variable starts from its held value so that no
    // branch of the case below can leave it unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    step_d     = step_q;
    retry_d    = retry_q;
    clk_low_d  = clk_low_q;
    data_low_d = data_low_q;
    do_retry   = 1'b0;

    next_step = step_q + 3'd1;
    cur_value = seq_value(step_q);
    limit     = (step_q == SEQ_BAT_STEP) ? cnt_t'(BAT_CYCLES - 1) : cnt_t'(TIMEOUT_CYCLES - 1);
    timed_out = (cnt_q >= limit) && !clk_fall;

    // Watchdog for every state that waits on the device clock.
    if (state_q inside {ST_RTS, ST_TX_BIT, ST_TX_ACK, ST_RX_BIT}) begin
      cnt_d = clk_fall ? '0 : cnt_q + cnt_t'(1);
    end

    case (state_q)
      ST_INHIBIT: begin
        // Device falls here are ignored: only the counter matters.
        clk_low_d = 1'b1;
        cnt_d     = cnt_q + cnt_t'(1);
        if (cnt_q == cnt_t'(INHIBIT_CYCLES + 1)) begin
          state_d    = ST_RTS;
          clk_low_d  = 1'b0;
          data_low_d = 1'b1;
          cnt_d      = '0;
          bit_cnt_d  = '0;
          shift_d    = {odd_parity(cur_value), cur_value};
        end else begin
          // Start bit goes out for one cycle while the clock is still held.
          data_low_d = (cnt_q == cnt_t'(INHIBIT_CYCLES));
        end
      end

      ST_RTS: begin
        if (clk_fall) begin
          state_d    = ST_TX_BIT;
          data_low_d = ~shift_q[0];
          shift_d    = {1'b0, shift_q[8:1]};
          bit_cnt_d  = 4'd1;
        end else if (timed_out) begin
          do_retry = 1'b1;
        end
      end

      ST_TX_BIT: begin
        if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < 4'd9) begin
            // Falls 2..8 carry data bits 1..7, fall 9 carries parity.
            data_low_d = ~shift_q[0];
            shift_d    = {1'b0, shift_q[8:1]};
          end else begin
            data_low_d = 1'b0;  // release: stop bit reads as 1
            state_d    = ST_TX_ACK;
          end
        end else if (timed_out) begin
          do_retry = 1'b1;
        end
      end

      ST_TX_ACK: begin
        if (clk_fall) begin
          if (!data_s) begin
            step_d    = next_step;
            bit_cnt_d = '0;
            state_d   = ST_RX_BIT;
          end else begin
            do_retry = 1'b1;
          end
        end else if (timed_out) begin
          do_retry = 1'b1;
        end
      end

      ST_RX_BIT: begin
        if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd0) begin
            if (data_s) do_retry = 1'b1;  // start bit must be 0
          end else if (bit_cnt_q < 4'(PS2_FRAME_LEN - 1)) begin
            shift_d = {data_s, shift_q[8:1]};
          end else if (data_s && (^shift_q)) begin
            state_d = ST_CHECK;
          end else begin
            do_retry = 1'b1;  // bad stop bit or parity
          end
        end else if (timed_out) begin
          do_retry = 1'b1;
        end
      end

      ST_CHECK: begin
        // A resend request (FE) simply fails the compare.
        if (shift_q[7:0] != cur_value) begin
          do_retry = 1'b1;
        end else if (step_q == SEQ_LAST) begin
          state_d    = ST_DONE;
          clk_low_d  = 1'b0;
          data_low_d = 1'b0;
        end else begin
          step_d    = next_step;
          bit_cnt_d = '0;
          cnt_d     = '0;
          if (seq_is_tx(next_step)) begin
            state_d    = ST_INHIBIT;
            clk_low_d  = 1'b1;
            data_low_d = 1'b0;
          end else begin
            state_d = ST_RX_BIT;
          end
        end
      end

      default: begin  // ST_DONE, ST_FAIL: lines released, traffic ignored
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
      end
    endcase

    if (do_retry) begin
      if (retry_q == 2'(MAX_RETRIES)) begin
        state_d    = ST_FAIL;
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
      end else begin
        retry_d    = retry_q + 2'd1;
        state_d    = ST_INHIBIT;
        step_d     = '0;
        cnt_d      = '0;
        bit_cnt_d  = '0;
        clk_low_d  = 1'b1;
        data_low_d = 1'b0;
      end
    end

    busy_d   = (state_d != ST_DONE) && (state_d != ST_FAIL);
    stream_d = (state_d == ST_DONE);
    error_d  = (state_d == ST_FAIL);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_INHIBIT;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      step_q     <= '0;
      retry_q    <= '0;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      stream_q   <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      step_q     <= step_d;
      retry_q    <= retry_d;
      clk_low_q  <= clk_low_d;
      data_low_q <= data_low_d;
      stream_q   <= stream_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  assign o_PS2Clk_drive_low  = clk_low_q;
  assign o_PS2Data_drive_low = data_low_q;
  assign o_stream_en         = stream_q;
  assign o_busy              = busy_q;
  assign o_error             = error_q;
  assign o_retry_cnt         = retry_q;

endmodule
